// File: rtl/spart_pkg.sv
// spart_pkg: shared SPART receive constants and state encoding.
package spart_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;
    localparam int   OVERSAMPLE_DEF = 16;
    localparam logic IDLE_LEVEL     = 1'b1;
endpackage

// File: rtl/spart_sync.sv
// spart_sync: metastability flop chain for an asynchronous input, resets to the idle line level.
module spart_sync
    import spart_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst)
        if (rst) chain <= {STAGES{IDLE_LEVEL}};
        else     chain <= {chain[STAGES-2:0], d};

    assign q = chain[STAGES-1];
endmodule

// File: rtl/spart_rx.sv
// spart_rx: SPART receiver, 16x oversampled 8N1 deserialiser with rda/error flags.
// Define SPART_RX_PARITY_EN to add an even-parity bit between data and stop.
module spart_rx
    import spart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_enable,
    input  logic                 rxd,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rda,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    rx_state_t             state;
    logic [TW-1:0]         tick;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_BITS-1:0]  sh;
    logic                  s;
    logic                  prev;
    logic                  at_half;
    logic                  at_full;
    logic                  done;

    spart_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(rxd), .q(s));

    assign at_half = tick == T_HALF;
    assign at_full = tick == T_FULL;
    assign done    = rx_enable && state == STOP && at_full;

`ifdef SPART_RX_PARITY_EN
    logic par;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tick      <= '0;
            bit_cnt   <= '0;
            sh        <= '0;
            prev      <= IDLE_LEVEL;
            rx_data   <= '0;
            rda       <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef SPART_RX_PARITY_EN
            par        <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            if (rx_enable) begin
                prev <= s;
                tick <= tick + 1'b1;
                case (state)
                    IDLE: begin
                        tick <= '0;
                        if (!s && prev) state <= START;
                    end
                    START: if (at_half) begin
                        tick    <= '0;
                        bit_cnt <= '0;
                        state   <= s ? IDLE : DATA;
                    end
                    DATA: if (at_full) begin
                        tick    <= '0;
                        sh      <= {s, sh[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
`ifdef SPART_RX_PARITY_EN
                        if (bit_cnt == B_LAST) state <= PARITY;
`else
                        if (bit_cnt == B_LAST) state <= STOP;
`endif
                    end
`ifdef SPART_RX_PARITY_EN
                    PARITY: if (at_full) begin
                        tick  <= '0;
                        par   <= s;
                        state <= STOP;
                    end
`endif
                    STOP: if (at_full) begin
                        tick  <= '0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
            // A read in the completion cycle consumes the old byte, so it cannot overrun.
            if (done) begin
                rx_data   <= sh;
                rda       <= 1'b1;
                frame_err <= ~s;
                overrun   <= rda & ~rd_ack;
`ifdef SPART_RX_PARITY_EN
                parity_err <= ^{sh, par};
`endif
            end else if (rd_ack) begin
                rda       <= 1'b0;
                frame_err <= 1'b0;
                overrun   <= 1'b0;
`ifdef SPART_RX_PARITY_EN
                parity_err <= 1'b0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_spart_rx.sv
// tb_spart_rx: directed bench for spart_rx; rx_enable every 4 clks, 16 ticks per bit.
module tb_spart_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_enable = 1'b0;
    logic       rxd = 1'b1;
    logic       rd_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rda;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;
    logic [1:0] ph = 2'd0;
    int         n_chk = 0;
    int         n_fail = 0;

    spart_rx dut (
        .clk(clk), .rst(rst), .rx_enable(rx_enable), .rxd(rxd), .rd_ack(rd_ack),
        .rx_data(rx_data), .rda(rda), .frame_err(frame_err), .overrun(overrun),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ph        <= ph + 2'd1;
        rx_enable <= ph == 2'd3;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: bench did not finish, observed timeout required completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Returns 1 time unit after the next clock edge on which rx_enable is high.
    task automatic step();
        do @(posedge clk); while (!rx_enable);
        #1;
    endtask

    task automatic ack();
        @(posedge clk);
        #1 rd_ack = 1'b1;
        @(posedge clk);
        #1 rd_ack = 1'b0;
    endtask

    // Stop-bit centre is sampled 9 ticks after the stop level is driven.
    task automatic send(input logic [7:0] d, input logic stop, input logic par_flip,
                        input logic ack_done, input logic chk_lat);
        logic pbit;
        pbit = ^d ^ par_flip;
        step();
        rxd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (16) step();
            rxd = d[i];
        end
`ifdef SPART_RX_PARITY_EN
        repeat (16) step();
        rxd = pbit;
`endif
        repeat (16) step();
        rxd = stop;
        repeat (8) step();
        if (chk_lat) chk("rda_before_stop_centre", {7'd0, rda}, 8'h00);
        if (ack_done) begin
            repeat (3) @(posedge clk);
            #1 rd_ack = 1'b1;
            @(posedge clk);
            #1 rd_ack = 1'b0;
        end else step();
        if (chk_lat) chk("rda_after_stop_centre", {7'd0, rda}, 8'h01);
        repeat (7) step();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rx_data", rx_data, 8'h00);
        chk("reset_rda", {7'd0, rda}, 8'h00);
        chk("reset_flags", {5'd0, frame_err, overrun, parity_err}, 8'h00);
        rst = 1'b0;
        repeat (4) step();

        send(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t1_rx_data", rx_data, 8'hA5);
        chk("t1_flags", {5'd0, frame_err, overrun, parity_err}, 8'h00);
        ack();
        chk("t1_ack_rda", {7'd0, rda}, 8'h00);

        step();
        rxd = 1'b0;
        repeat (4) step();
        rxd = 1'b1;
        repeat (40) step();
        chk("t2_glitch_rda", {7'd0, rda}, 8'h00);
        chk("t2_glitch_rx_data", rx_data, 8'hA5);

        send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_rx_data", rx_data, 8'h3C);
        chk("t3_rda", {7'd0, rda}, 8'h01);
        chk("t3_frame_err", {7'd0, frame_err}, 8'h01);
        ack();
        chk("t3_ack_frame_err", {7'd0, frame_err}, 8'h00);
        repeat (48) step();
        chk("t3_held_low_rda", {7'd0, rda}, 8'h00);
        rxd = 1'b1;
        repeat (4) step();

        send(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        send(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t4_rx_data", rx_data, 8'h22);
        chk("t4_rda", {7'd0, rda}, 8'h01);
        chk("t4_overrun", {7'd0, overrun}, 8'h01);
        ack();
        chk("t4_ack_flags", {4'd0, rda, frame_err, overrun, parity_err}, 8'h00);
        chk("t4_ack_rx_data", rx_data, 8'h22);

        send(8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
        send(8'h7E, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t5_rx_data", rx_data, 8'h7E);
        chk("t5_rda", {7'd0, rda}, 8'h01);
        chk("t5_overrun", {7'd0, overrun}, 8'h00);

        step();
        rxd = 1'b0;
        repeat (16) step();
        rxd = 1'b1;
        repeat (56) step();
        rst = 1'b1;
        #1;
        chk("t6_rst_rx_data", rx_data, 8'h00);
        chk("t6_rst_flags", {4'd0, rda, frame_err, overrun, parity_err}, 8'h00);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (96) step();
        chk("t6_idle_rda", {7'd0, rda}, 8'h00);
        send(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t6_rx_data", rx_data, 8'h5A);
        chk("t6_flags", {5'd0, frame_err, overrun, parity_err}, 8'h00);

`ifdef SPART_RX_PARITY_EN
        ack();
        send(8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("par_bad_parity_err", {7'd0, parity_err}, 8'h01);
        ack();
        chk("par_ack_parity_err", {7'd0, parity_err}, 8'h00);
        send(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("par_good_parity_err", {7'd0, parity_err}, 8'h00);
        chk("par_good_rx_data", rx_data, 8'h01);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
